// File: rtl/sqrt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_seq_pkg
// Brief    : Shared types and elaboration helpers for the sequential square
//            root (state encoding, root width / iteration count derivation,
//            parameter legality check).
// Revision : 1.0 - initial release
// ============================================================================
package sqrt_seq_pkg;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_CALC = 2'd1,
        SQ_DONE = 2'd2
    } sq_state_e;

    // Root width: one root bit per operand bit pair, odd widths round up.
    function automatic int sq_part(input int width);
        return (width + 1) / 2;
    endfunction

    // Number of CALC cycles needed to resolve the whole root.
    function automatic int sq_iter(input int width, input int bpc);
        return sq_part(width) / bpc;
    endfunction

    // Legal instance: at least two operand bits, binary TC_MODE, and the
    // per-cycle step count must tile the root width exactly.
    function automatic bit sq_params_ok(input int width, input int tc_mode, input int bpc);
        return (width >= 2) && (tc_mode == 0 || tc_mode == 1) &&
               (bpc >= 1) && (bpc <= sq_part(width)) &&
               ((sq_part(width) % bpc) == 0);
    endfunction

endpackage : sqrt_seq_pkg
`default_nettype wire

// File: rtl/sqrt_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_step
// Brief    : One combinational restoring square-root step. Brings in the
//            next operand bit pair, tries (root<<2)|1 against the shifted
//            remainder and resolves one root bit.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_step #(
    parameter int PART = 16
) (
    input  logic [PART+1:0] i_rem,
    input  logic [PART-1:0] i_root,
    input  logic [1:0]      i_bits,
    output logic [PART+1:0] o_rem,
    output logic [PART-1:0] o_root
);

    logic [PART+1:0] w_rem_sh;
    logic [PART+1:0] w_trial;
    logic            w_ge;

    // Restoring step; the remainder never exceeds 2*root, so shifting it
    // left by two inside PART+2 bits cannot lose significant bits.
    always_comb begin
        w_rem_sh = (i_rem << 2) | {{PART{1'b0}}, i_bits};
        w_trial  = {i_root, 2'b01};
        w_ge     = (w_rem_sh >= w_trial);
        o_rem    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
        o_root   = (i_root << 1) | PART'(w_ge);
    end

endmodule : sqrt_step
`default_nettype wire

// File: rtl/sqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_seq
// Brief    : Sequential integer square root with valid/ready handshakes.
//            Produces floor(sqrt(|a|)), |a| - root^2 and a negative flag,
//            resolving BITS_PER_CYC root bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_seq
    import sqrt_seq_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int TC_MODE      = 1,
    parameter int BITS_PER_CYC = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [sq_part(WIDTH)-1:0]         root,
    output logic [sq_part(WIDTH):0]           remainder,
    output logic                              neg
);

    localparam int PART = sq_part(WIDTH);
    localparam int ITER = sq_iter(WIDTH, BITS_PER_CYC);
    localparam int OPW  = 2 * PART;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    if (!sq_params_ok(WIDTH, TC_MODE, BITS_PER_CYC)) begin : g_param_check
        $error("sqrt_seq: illegal WIDTH/TC_MODE/BITS_PER_CYC combination");
    end

    sq_state_e          r_state;
    sq_state_e          w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_in_ready_d;
    logic               w_out_valid_d;

    logic [CW-1:0]      r_cnt;
    logic [OPW-1:0]     r_opd;
    logic [PART+1:0]    r_prem;
    logic [PART-1:0]    r_proot;
    logic               r_neg_cap;
    logic [PART-1:0]    r_root;
    logic [PART:0]      r_rem;
    logic               r_neg;

    logic               w_neg_in;
    logic [WIDTH-1:0]   w_mag;
    logic               w_accept;
    logic               w_last;

    logic [PART+1:0]    w_rem_c  [BITS_PER_CYC+1];
    logic [PART-1:0]    w_root_c [BITS_PER_CYC+1];

    // Operand magnitude; (~a)+1 maps the most negative value to 2^(WIDTH-1).
    always_comb begin
        w_neg_in = (TC_MODE != 0) && a[WIDTH-1];
        w_mag    = w_neg_in ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
        w_accept = in_valid && r_in_ready && (r_state == SQ_IDLE);
        w_last   = (r_cnt == CW'(ITER - 1));
    end

    assign w_rem_c[0]  = r_prem;
    assign w_root_c[0] = r_proot;

    for (genvar j = 0; j < BITS_PER_CYC; j++) begin : g_step
        sqrt_step #(
            .PART (PART)
        ) u_step (
            .i_rem  (w_rem_c[j]),
            .i_root (w_root_c[j]),
            .i_bits (r_opd[OPW-1-2*j -: 2]),
            .o_rem  (w_rem_c[j+1]),
            .o_root (w_root_c[j+1])
        );
    end

    // State register; handshake flags are registered decodes of next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SQ_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
        end
    end

    // Next-state logic; clear overrides every handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = SQ_IDLE;
        end else begin
            case (r_state)
                SQ_IDLE: if (w_accept)  w_state_nxt = SQ_CALC;
                SQ_CALC: if (w_last)    w_state_nxt = SQ_DONE;
                SQ_DONE: if (out_ready) w_state_nxt = SQ_IDLE;
                default:                w_state_nxt = SQ_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the flags come straight from flops.
    always_comb begin
        w_in_ready_d  = (w_state_nxt == SQ_IDLE);
        w_out_valid_d = (w_state_nxt == SQ_DONE);
    end

    // Datapath: capture operand, iterate, publish result on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt     <= '0;
            r_opd     <= '0;
            r_prem    <= '0;
            r_proot   <= '0;
            r_neg_cap <= 1'b0;
            r_root    <= '0;
            r_rem     <= '0;
            r_neg     <= 1'b0;
        end else begin
            case (r_state)
                SQ_IDLE: begin
                    if (w_accept) begin
                        r_opd     <= OPW'(w_mag);
                        r_neg_cap <= w_neg_in;
                        r_prem    <= '0;
                        r_proot   <= '0;
                        r_cnt     <= '0;
                    end
                end
                SQ_CALC: begin
                    r_opd   <= r_opd << (2 * BITS_PER_CYC);
                    r_prem  <= w_rem_c[BITS_PER_CYC];
                    r_proot <= w_root_c[BITS_PER_CYC];
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_root <= w_root_c[BITS_PER_CYC];
                        r_rem  <= w_rem_c[BITS_PER_CYC][PART:0];
                        r_neg  <= r_neg_cap;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign root      = r_root;
    assign remainder = r_rem;
    assign neg       = r_neg;

endmodule : sqrt_seq
`default_nettype wire

// File: tb/tb_sqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_seq
// Brief    : Self-checking bench for sqrt_seq over several configurations
//            (unsigned/signed, 1..16 bits per cycle, odd width).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_seq;

    localparam int N = 7;

    // Instance table: 0 = W32 unsigned BPC1, 1..5 = W32 signed BPC 1/2/4/8/16,
    // 6 = W7 unsigned BPC2.
    function automatic int cfg_w(input int k);
        return (k == 6) ? 7 : 32;
    endfunction
    function automatic int cfg_tc(input int k);
        return (k == 0 || k == 6) ? 0 : 1;
    endfunction
    function automatic int cfg_b(input int k);
        return (k == 0 || k == 1) ? 1 : (k == 6) ? 2 : (1 << (k - 1));
    endfunction

    logic        clk = 1'b0;
    logic        rst_n_v     [N];
    logic        clear_v     [N];
    logic        in_valid_v  [N];
    logic        out_ready_v [N];
    logic [31:0] a_v         [N];
    wire         in_ready_v  [N];
    wire         out_valid_v [N];
    wire         neg_v       [N];
    wire  [31:0] root_v      [N];
    wire  [32:0] rem_v       [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int W = cfg_w(k);
        localparam int P = (W + 1) / 2;
        logic [P-1:0] w_root;
        logic [P:0]   w_rem;
        sqrt_seq #(
            .WIDTH        (W),
            .TC_MODE      (cfg_tc(k)),
            .BITS_PER_CYC (cfg_b(k))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_v[k]),
            .clear     (clear_v[k]),
            .in_valid  (in_valid_v[k]),
            .in_ready  (in_ready_v[k]),
            .a         (a_v[k][W-1:0]),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready_v[k]),
            .root      (w_root),
            .remainder (w_rem),
            .neg       (neg_v[k])
        );
        assign root_v[k] = 32'(w_root);
        assign rem_v[k]  = 33'(w_rem);
    end

    // Reference: floor square root of the magnitude by binary search.
    function automatic void model(input int w, input int tc, input logic [31:0] av,
                                  output longint r, output longint m, output logic n);
        longint va, mag, lo, hi, mid;
        va  = longint'(av) & ((longint'(1) << w) - 1);
        n   = (tc != 0) && av[w-1];
        mag = n ? ((longint'(1) << w) - va) : va;
        lo  = 0;
        hi  = longint'(1) << 17;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= mag) lo = mid;
            else                  hi = mid - 1;
        end
        r = lo;
        m = mag - lo * lo;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, return the result and the accept-to-valid latency.
    // The result is left pending (out_ready low) for the caller to release.
    task automatic run_op(input int k, input logic [31:0] av, input bit rnd,
                          output logic [31:0] r, output logic [32:0] m,
                          output logic n, output int lat);
        int c = 0;
        while (in_ready_v[k] !== 1'b1 && c < 200) begin
            step();
            c++;
        end
        in_valid_v[k] = 1'b1;
        a_v[k]        = av;
        step();
        in_valid_v[k] = 1'b0;
        lat = 0;
        while (out_valid_v[k] !== 1'b1 && lat < 200) begin
            if (rnd) begin
                in_valid_v[k]  = 1'($urandom_range(0, 1));
                a_v[k]         = $urandom;
                out_ready_v[k] = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
        end
        in_valid_v[k]  = 1'b0;
        out_ready_v[k] = 1'b0;
        r = root_v[k];
        m = rem_v[k];
        n = neg_v[k];
    endtask

    task automatic release_out(input int k);
        out_ready_v[k] = 1'b1;
        step();
        out_ready_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            rst_n_v[k] = 1'b0; clear_v[k] = 1'b0; in_valid_v[k] = 1'b0;
            out_ready_v[k] = 1'b0; a_v[k] = '0;
        end
        step();
        step();
        for (int k = 0; k < N; k++) rst_n_v[k] = 1'b1;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if ({in_ready_v[k], out_valid_v[k], neg_v[k]} !== 3'b100 ||
                root_v[k] !== 32'd0 || rem_v[k] !== 33'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b neg=%b root=%0d rem=%0d, expected 1 0 0 0 0",
                         k, in_ready_v[k], out_valid_v[k], neg_v[k], root_v[k], rem_v[k]);
            end
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] av   [3] = '{32'd0, 32'd1000000, 32'hFFFF_FFFF};
        logic [31:0] er   [3] = '{32'd0, 32'd1000, 32'd65535};
        logic [32:0] em   [3] = '{33'd0, 33'd0, 33'd131070};
        logic [31:0] r; logic [32:0] m; logic n; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(0, av[i], 1'b0, r, m, n, lat);
            n_checks++;
            if (r !== er[i] || m !== em[i] || n !== 1'b0 || lat != 16) begin
                n_fail++;
                $display("FAIL unsigned a=%h: root=%0d rem=%0d neg=%b lat=%0d, expected %0d %0d 0 16",
                         av[i], r, m, n, lat, er[i], em[i]);
            end
            release_out(0);
        end
    endtask

    task automatic test_signed();
        logic [31:0] av [3] = '{32'hFFFF_FFEF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] er [3] = '{32'd4, 32'd46340, 32'd46340};
        logic [32:0] em [3] = '{33'd1, 33'd88048, 33'd88047};
        logic        en [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] r; logic [32:0] m; logic n; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(1, av[i], 1'b0, r, m, n, lat);
            n_checks++;
            if (r !== er[i] || m !== em[i] || n !== en[i] || lat != 16) begin
                n_fail++;
                $display("FAIL signed a=%h: root=%0d rem=%0d neg=%b lat=%0d, expected %0d %0d %b 16",
                         av[i], r, m, n, lat, er[i], em[i], en[i]);
            end
            release_out(1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic [32:0] m; logic n; int lat;
        run_op(0, 32'd1000000, 1'b0, r, m, n, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid_v[0] = (i % 2 == 0);
            a_v[0]        = $urandom;
            step();
            n_checks++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 ||
                root_v[0] !== 32'd1000 || rem_v[0] !== 33'd0) begin
                n_fail++;
                $display("FAIL backpressure hold %0d: vld=%b rdy=%b root=%0d rem=%0d, expected 1 0 1000 0",
                         i, out_valid_v[0], in_ready_v[0], root_v[0], rem_v[0]);
            end
        end
        in_valid_v[0] = 1'b0;
        release_out(0);
        n_checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure release: vld=%b rdy=%b, expected 0 1", out_valid_v[0], in_ready_v[0]);
        end
        step();
        n_checks++;
        if (in_ready_v[0] !== 1'b1 || root_v[0] !== 32'd1000) begin
            n_fail++;
            $display("FAIL backpressure idle: rdy=%b root=%0d, expected 1 1000", in_ready_v[0], root_v[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r; logic [32:0] m; logic n; int lat;
        bit seen;
        for (int mode = 0; mode < 2; mode++) begin
            in_valid_v[0] = 1'b1;
            a_v[0]        = 32'hFFFF_FFFF;
            step();
            in_valid_v[0] = 1'b0;
            repeat (7) step();
            if (mode == 0) rst_n_v[0] = 1'b0;
            else           clear_v[0] = 1'b1;
            step();
            rst_n_v[0] = 1'b1;
            clear_v[0] = 1'b0;
            n_checks++;
            if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || root_v[0] !== 32'd0) begin
                n_fail++;
                $display("FAIL abort mode %0d: rdy=%b vld=%b root=%0d, expected 1 0 0",
                         mode, in_ready_v[0], out_valid_v[0], root_v[0]);
            end
            seen = 1'b0;
            repeat (20) begin
                step();
                if (out_valid_v[0] === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (seen !== 1'b0) begin
                n_fail++;
                $display("FAIL abort mode %0d no-result: out_valid seen=%b, expected 0", mode, seen);
            end
            run_op(0, 32'd144, 1'b0, r, m, n, lat);
            n_checks++;
            if (r !== 32'd12 || m !== 33'd0 || lat != 16) begin
                n_fail++;
                $display("FAIL abort mode %0d a=144: root=%0d rem=%0d lat=%0d, expected 12 0 16", mode, r, m, lat);
            end
            release_out(0);
        end
        clear_v[0]    = 1'b1;
        in_valid_v[0] = 1'b1;
        a_v[0]        = 32'd5;
        step();
        clear_v[0]    = 1'b0;
        in_valid_v[0] = 1'b0;
        n_checks++;
        if (in_ready_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear-priority: in_ready=%b, expected 1", in_ready_v[0]);
        end
    endtask

    task automatic test_w7();
        logic [31:0] r; logic [32:0] m; logic n; int lat;
        longint er, em; logic en;
        int bad = 0;
        run_op(6, 32'd127, 1'b0, r, m, n, lat);
        n_checks++;
        if (r !== 32'd11 || m !== 33'd6 || lat != 2) begin
            n_fail++;
            $display("FAIL w7 a=127: root=%0d rem=%0d lat=%0d, expected 11 6 2", r, m, lat);
        end
        release_out(6);
        for (int v = 0; v < 128; v++) begin
            run_op(6, 32'(v), 1'b0, r, m, n, lat);
            model(7, 0, 32'(v), er, em, en);
            n_checks++;
            if (longint'(r) != er || longint'(m) != em || n !== en || lat != 2) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL w7 sweep a=%0d: root=%0d rem=%0d neg=%b lat=%0d, expected %0d %0d %b 2",
                             v, r, m, n, lat, er, em, en);
            end
            release_out(6);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] av, r; logic [32:0] m; logic n; int lat;
        longint er, em; logic en;
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 40; i++) begin
                av = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
                repeat ($urandom_range(0, 3)) step();
                run_op(k, av, 1'b1, r, m, n, lat);
                model(32, 1, av, er, em, en);
                n_checks++;
                if (longint'(r) != er || longint'(m) != em || n !== en || lat != 16 / cfg_b(k)) begin
                    n_fail++;
                    $display("FAIL random bpc=%0d a=%h: root=%0d rem=%0d neg=%b lat=%0d, expected %0d %0d %b %0d",
                             cfg_b(k), av, r, m, n, lat, er, em, en, 16 / cfg_b(k));
                end
                repeat ($urandom_range(0, 4)) step();
                release_out(k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_abort();
        test_w7();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sqrt_seq
`default_nettype wire
